// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
package uart_pkg;

   localparam int unsigned UART_CLKS_PER_BIT = 435;
   localparam int unsigned UART_DATA_BITS    = 8;
   // Start + data + stop: the serial frame length used by the transmitter.
   localparam int unsigned UART_FRAME_BITS   = UART_DATA_BITS + 2;
   localparam int unsigned UART_CNT_W        = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous input, reset to RESET_VAL.
module bit_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] r_sync;

   // Shift the raw input through two flops to settle metastability.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= {2{RESET_VAL}};
      else       r_sync <= {r_sync[0], i_d};
   end

   assign o_q = r_sync[1];

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid / framing-error pulses.
module uart_receive
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rxd,
   output logic [UART_DATA_BITS-1:0] dataOutput,
   output logic                      dataValid,
   output logic                      frameError,
   output logic                      busy
);

   localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
   localparam int unsigned IDX_W    = $clog2(UART_DATA_BITS);
   localparam logic [UART_CNT_W-1:0] HALF_CNT = UART_CNT_W'(HALF_BIT);
   localparam logic [UART_CNT_W-1:0] LAST_CNT = UART_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

   uart_rx_state_t            r_state, w_state_n;
   logic [UART_CNT_W-1:0]     r_cnt, w_cnt_n;
   logic [IDX_W-1:0]          r_idx, w_idx_n;
   logic [UART_DATA_BITS-1:0] r_shift, w_shift_n;
   logic [UART_DATA_BITS-1:0] r_data, w_data_n;
   logic                      r_valid, w_valid_n;
   logic                      r_ferr, w_ferr_n;
   logic                      r_busy, w_busy_n;
   logic                      w_rxs;

   bit_sync #(.RESET_VAL(1'b1)) u_rxd_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (rxd),
      .o_q   (w_rxs)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_idx   <= w_idx_n;
         r_shift <= w_shift_n;
         r_data  <= w_data_n;
         r_valid <= w_valid_n;
         r_ferr  <= w_ferr_n;
         r_busy  <= w_busy_n;
      end
   end

   // Next-state logic: counter clears on every state entry, samples at bit mid-points.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt + UART_CNT_W'(1);
      w_idx_n   = r_idx;
      w_shift_n = r_shift;
      w_data_n  = r_data;
      w_valid_n = 1'b0;
      w_ferr_n  = 1'b0;

      case (r_state)
         IDLE: begin
            w_cnt_n = '0;
            if (!w_rxs) w_state_n = START;
         end
         START: begin
            if (r_cnt == HALF_CNT) begin
               w_cnt_n = '0;
               if (!w_rxs) begin
                  w_state_n = DATA;
                  w_idx_n   = '0;
               end else begin
                  // Line went back high before mid start bit: treat as a glitch.
                  w_state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (r_cnt == LAST_CNT) begin
               w_cnt_n          = '0;
               w_shift_n[r_idx] = w_rxs;
               if (r_idx == LAST_IDX) w_state_n = STOP;
               else                   w_idx_n   = r_idx + IDX_W'(1);
            end
         end
         STOP: begin
            if (r_cnt == LAST_CNT) begin
               w_cnt_n = '0;
               if (w_rxs) begin
                  // Leave mid-stop-bit so a back-to-back start edge is caught.
                  w_data_n  = r_shift;
                  w_valid_n = 1'b1;
                  w_state_n = IDLE;
               end else begin
                  w_ferr_n  = 1'b1;
                  w_state_n = BREAK;
               end
            end
         end
         BREAK: begin
            // Hold here while the line is low so a break is not re-read as starts.
            w_cnt_n = '0;
            if (w_rxs) w_state_n = IDLE;
         end
         default: begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
         end
      endcase

      w_busy_n = (w_state_n != IDLE);
   end

   assign dataOutput = r_data;
   assign dataValid  = r_valid;
   assign frameError = r_ferr;
   assign busy       = r_busy;

endmodule
